riscv_trace_buffer: RTL and testbench
=====================================

RISCV_TRACE_BUFFER -- requirements
Module: riscv_trace_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the width of one channel in bits.
REQ-002 SHALL have parameter NCH, default 2, meaning the number of channels captured per sample (e.g. PC and Instr).
REQ-003 SHALL have parameter DEPTH, default 64, meaning the sample storage depth; it SHALL be a power of 2 and at least 4.
REQ-004 SHALL have parameter PRE_TRIG, default 16, meaning the maximum number of samples kept from before the trigger; it SHALL be less than DEPTH.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port Resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port arm, input, 1 bit: starts a capture when the block is in IDLE.
REQ-008 SHALL have port abort, input, 1 bit: returns the block to IDLE from any state.
REQ-009 SHALL have port in_valid, input, 1 bit: in_data holds a sample this cycle.
REQ-010 SHALL have port in_data, input, NCH*DATA_W bits: the sample; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-011 SHALL have port trig, input, 1 bit: the trigger event.
REQ-012 SHALL have port rd_ready, input, 1 bit: the consumer accepts rd_data.
REQ-013 SHALL have port rd_valid, output, 1 bit: rd_data holds a captured sample.
REQ-014 SHALL have port rd_data, output, NCH*DATA_W bits: the oldest unread sample.
REQ-015 SHALL have port rd_last, output, 1 bit: rd_data is the final captured sample.
REQ-016 SHALL have port state, output, 2 bits: 0 IDLE, 1 ARMED, 2 POST, 3 DONE.
REQ-017 SHALL have port count, output, $clog2(DEPTH)+1 bits: the number of samples held.

Function
REQ-018 In IDLE, arm=1 and abort=0 SHALL move the block to ARMED and clear count and the pointers; arm SHALL be ignored in every other state.
REQ-019 In ARMED, each in_valid sample SHALL be written circularly; count SHALL saturate at PRE_TRIG, with the oldest sample dropped once saturated.
REQ-020 In ARMED, trig=1 SHALL move the block to POST. If in_valid=1 in the same cycle, that sample SHALL be stored as the first post-trigger sample; if in_valid=0, no sample is stored.
REQ-021 In POST, each in_valid sample SHALL be stored until DEPTH-PRE_TRIG post-trigger samples are held, then the block SHALL enter DONE on the same edge that stores the last one; trig SHALL be ignored in POST.
REQ-022 Final count SHALL be min(pre-trigger samples, PRE_TRIG) + (DEPTH-PRE_TRIG); pointer arithmetic SHALL be modulo DEPTH.
REQ-023 In DONE, rd_valid SHALL be 1 while count>0; rd_data SHALL present the oldest sample combinationally from storage.
REQ-024 rd_data SHALL be held stable while rd_valid=1 and rd_ready=0.
REQ-025 A handshake (rd_valid & rd_ready) SHALL advance the read pointer and decrement count by 1.
REQ-026 rd_last SHALL be 1 exactly when rd_valid=1 and count=1; the handshake on that word SHALL return the block to IDLE.
REQ-027 abort SHALL win over arm, trig and handshake; the next state SHALL be IDLE with count=0 and rd_valid=0.
REQ-028 in_valid in IDLE or DONE SHALL be ignored.

Reset
REQ-029 Resetn=0 SHALL asynchronously force state=IDLE, count=0, write/read pointers=0, rd_valid=0 and rd_last=0, including in the middle of a capture or a readout.
REQ-030 Storage contents SHALL NOT be reset; rd_data is don't-care while rd_valid=0.

Structure
REQ-031 A shared package riscv_dbg_pkg SHALL hold the state encodings (IDLE/ARMED/POST/DONE) and the channel index constants (CH_PC=0, CH_INSTR=1).
REQ-032 Storage SHALL be one sub-module, trace_ram: DEPTH x NCH*DATA_W, one synchronous write port and one asynchronous read port.
REQ-033 The control FSM, pointers and counters SHALL live in riscv_trace_buffer.

Verification (DEPTH=8, PRE_TRIG=3, NCH=2, DATA_W=32; sample n has both channels = n)
REQ-034 Arm, samples 1..10 each cycle, trig with sample 6 -> DONE after sample 10, count=8, readout 3,4,5,6,7,8,9,10, rd_last on 10, then IDLE.
REQ-035 Arm, trig together with sample 1 -> POST stores 1..5, count=5, readout 1..5.
REQ-036 Arm, samples 1,2, then trig with in_valid=0, then samples 3..7 -> readout 1..7 (7 words).
REQ-037 Arm, samples 1..20, trig with 21 (pointer wrap) -> readout 18..25; with rd_ready toggling 1,0,0,1 -> rd_data stable through the stalls, and no sample lost or duplicated.
REQ-038 abort in the second POST cycle -> IDLE next edge, count=0; Resetn pulsed low mid-readout -> immediate IDLE, rd_valid=0, and a fresh arm captures correctly.

Source files
------------

// File: rtl/riscv_dbg_pkg.sv
// Shared debug definitions: trace buffer state encoding and channel indices.
package riscv_dbg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } trace_state_e;

    localparam int CH_PC    = 0;
    localparam int CH_INSTR = 1;

endpackage

// File: rtl/trace_ram.sv
// Trace sample storage: one synchronous write port, one asynchronous read port.
module trace_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/riscv_trace_buffer.sv
// Pre/post-trigger trace capture: keeps up to PRE_TRIG samples before the
// trigger and DEPTH-PRE_TRIG after it, then streams them out oldest first.
module riscv_trace_buffer
    import riscv_dbg_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NCH      = 2,
    parameter int DEPTH    = 64,
    parameter int PRE_TRIG = 16
) (
    input  logic                    CLK,
    input  logic                    Resetn,
    input  logic                    arm,
    input  logic                    abort,
    input  logic                    in_valid,
    input  logic [NCH*DATA_W-1:0]   in_data,
    input  logic                    trig,
    input  logic                    rd_ready,
    output logic                    rd_valid,
    output logic [NCH*DATA_W-1:0]   rd_data,
    output logic                    rd_last,
    output logic [1:0]              state,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] PRE_CNT  = CW'(PRE_TRIG);
    localparam logic [CW-1:0] POST_CNT = CW'(DEPTH - PRE_TRIG);

    trace_state_e    state_q, state_d;
    logic [AW-1:0]   wrPtr_q, wrPtr_d;
    logic [AW-1:0]   rdPtr_q, rdPtr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   postCnt_q, postCnt_d;
    logic            writeEn;
    logic            storePost;
    logic            handshake;

    assign rd_valid  = (state_q == DONE) && (count_q != '0);
    assign rd_last   = rd_valid && (count_q == CW'(1));
    assign handshake = rd_valid && rd_ready;
    assign storePost = in_valid && ((state_q == POST) || ((state_q == ARMED) && trig));
    assign state     = state_q;
    assign count     = count_q;

    // Once the pre-trigger window is full, each new sample evicts the oldest
    // by moving the read pointer along with the write pointer.
    always_comb begin
        state_d   = state_q;
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        count_d   = count_q;
        postCnt_d = postCnt_q;
        writeEn   = 1'b0;

        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d   = ARMED;
                    wrPtr_d   = '0;
                    rdPtr_d   = '0;
                    count_d   = '0;
                    postCnt_d = '0;
                end
            end
            ARMED: begin
                if (trig) begin
                    state_d = POST;
                end else if (in_valid) begin
                    writeEn = 1'b1;
                    wrPtr_d = wrPtr_q + AW'(1);
                    if (count_q == PRE_CNT) begin
                        rdPtr_d = rdPtr_q + AW'(1);
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            POST: ;
            DONE: begin
                if (handshake) begin
                    rdPtr_d = rdPtr_q + AW'(1);
                    count_d = count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (storePost) begin
            writeEn   = 1'b1;
            wrPtr_d   = wrPtr_q + AW'(1);
            count_d   = count_q + CW'(1);
            postCnt_d = postCnt_q + CW'(1);
            if (postCnt_q + CW'(1) == POST_CNT) begin
                state_d = DONE;
            end
        end

        if (abort) begin
            state_d   = IDLE;
            wrPtr_d   = '0;
            rdPtr_d   = '0;
            count_d   = '0;
            postCnt_d = '0;
            writeEn   = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= IDLE;
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            postCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            postCnt_q <= postCnt_d;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (NCH * DATA_W),
        .AW    (AW)
    ) u_ram (
        .clk_i   (CLK),
        .we_i    (writeEn),
        .waddr_i (wrPtr_q),
        .wdata_i (in_data),
        .raddr_i (rdPtr_q),
        .rdata_o (rd_data)
    );

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Trace buffer bench: directed capture scenarios plus randomized captures
// checked against a queue-based model of the pre/post trigger windows.
module tb_riscv_trace_buffer;

    localparam int DATA_W   = 32;
    localparam int NCH      = 2;
    localparam int DEPTH    = 8;
    localparam int PRE_TRIG = 3;
    localparam int W        = NCH * DATA_W;
    localparam int POST_N   = DEPTH - PRE_TRIG;

    logic         CLK = 1'b0;
    logic         Resetn;
    logic         arm, abort, in_valid, trig, rd_ready;
    logic [W-1:0] in_data;
    logic         rd_valid, rd_last;
    logic [W-1:0] rd_data;
    logic [1:0]   state;
    logic [3:0]   count;

    int checks   = 0;
    int failures = 0;

    // Model: phase 0 idle, 1 armed, 2 post, 3 done; queues hold the windows.
    int           mPhase = 0;
    logic [W-1:0] preQ[$];
    logic [W-1:0] postQ[$];

    riscv_trace_buffer #(
        .DATA_W   (DATA_W),
        .NCH      (NCH),
        .DEPTH    (DEPTH),
        .PRE_TRIG (PRE_TRIG)
    ) dut (
        .CLK      (CLK),
        .Resetn   (Resetn),
        .arm      (arm),
        .abort    (abort),
        .in_valid (in_valid),
        .in_data  (in_data),
        .trig     (trig),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_last  (rd_last),
        .state    (state),
        .count    (count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [W-1:0] smp(input int n);
        return {DATA_W'(n), DATA_W'(n)};
    endfunction

    function automatic int modelCount();
        return (mPhase == 0) ? 0 : preQ.size() + postQ.size();
    endfunction

    // One capture-side clock cycle: drive inputs, advance the model, check state/count.
    task automatic applyStimulus(input logic v, input logic t, input logic [W-1:0] d,
                                 input logic a, input logic ab);
        arm = a; abort = ab; in_valid = v; trig = t; in_data = d; rd_ready = 1'b0;
        if (ab) begin
            mPhase = 0; preQ.delete(); postQ.delete();
        end else if (mPhase == 0) begin
            if (a) begin
                mPhase = 1; preQ.delete(); postQ.delete();
            end
        end else if (mPhase == 1) begin
            if (t) begin
                mPhase = 2;
                if (v) postQ.push_back(d);
            end else if (v) begin
                preQ.push_back(d);
                if (preQ.size() > PRE_TRIG) void'(preQ.pop_front());
            end
        end else if (mPhase == 2 && v) begin
            postQ.push_back(d);
        end
        if (mPhase == 2 && postQ.size() == POST_N) mPhase = 3;
        @(posedge CLK); #1;
        arm = 1'b0; abort = 1'b0; in_valid = 1'b0; trig = 1'b0;
        checks++;
        if (state !== 2'(mPhase)) begin
            failures++;
            $display("[TB] FAIL cap_state got=%0d want=%0d", state, mPhase);
        end
        checks++;
        if (count !== 4'(modelCount())) begin
            failures++;
            $display("[TB] FAIL cap_count got=%0d want=%0d", count, modelCount());
        end
    endtask

    // Read out the whole capture; mode 0 always ready, 1 pattern 1,0,0,1, 2 random.
    task automatic drain(input int mode, input int stopAfter);
        logic [W-1:0] expQ[$];
        int idx, n;
        logic rdy;
        expQ = {preQ, postQ};
        n = expQ.size();
        idx = 0;
        for (int cyc = 0; cyc < 200 && idx < n && idx < stopAfter; cyc++) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== expQ[idx]) begin
                failures++;
                $display("[TB] FAIL rd_word idx=%0d valid=%b got=%h want=%h", idx, rd_valid, rd_data, expQ[idx]);
            end
            checks++;
            if (rd_last !== (idx == n - 1) || count !== 4'(n - idx)) begin
                failures++;
                $display("[TB] FAIL rd_last_count idx=%0d last=%b count=%0d want_count=%0d", idx, rd_last, count, n - idx);
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            rd_ready = rdy;
            in_valid = 1'($urandom_range(0, 1));
            trig     = 1'($urandom_range(0, 1));
            in_data  = {$urandom, $urandom};
            @(posedge CLK); #1;
            if (rdy) idx++;
        end
        rd_ready = 1'b0; in_valid = 1'b0; trig = 1'b0;
        if (idx < stopAfter && idx < n) begin
            checks++; failures++;
            $display("[TB] FAIL rd_timeout read=%0d want=%0d", idx, n);
        end
        if (idx >= n) begin
            mPhase = 0; preQ.delete(); postQ.delete();
            checks++;
            if (state !== 2'd0 || rd_valid !== 1'b0 || count !== 4'd0) begin
                failures++;
                $display("[TB] FAIL rd_end state=%0d valid=%b count=%0d want 0/0/0", state, rd_valid, count);
            end
        end
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        arm = 1'b0; abort = 1'b0; in_valid = 1'b0; trig = 1'b0; rd_ready = 1'b0; in_data = '0;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (state !== 2'd0 || count !== 4'd0 || rd_valid !== 1'b0 || rd_last !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset state=%0d count=%0d valid=%b last=%b want 0", state, count, rd_valid, rd_last);
        end
        Resetn = 1'b1;
    endtask

    task automatic test_basic();
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
        for (int n = 1; n <= 10; n++) applyStimulus(1'b1, (n == 6), smp(n), 1'b0, 1'b0);
        drain(0, 100);
    endtask

    task automatic test_trig_first();
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
        for (int n = 1; n <= 5; n++) applyStimulus(1'b1, (n == 1), smp(n), 1'b0, 1'b0);
        drain(0, 100);
    endtask

    task automatic test_trig_novalid();
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, smp(1), 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, smp(2), 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, smp(99), 1'b0, 1'b0);
        for (int n = 3; n <= 7; n++) applyStimulus(1'b1, 1'b0, smp(n), 1'b0, 1'b0);
        drain(0, 100);
    endtask

    task automatic test_wrap_stall();
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
        for (int n = 1; n <= 25; n++) applyStimulus(1'b1, (n == 21), smp(n), 1'b0, 1'b0);
        drain(1, 100);
    endtask

    task automatic test_abort();
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, smp(1), 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, smp(2), 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, smp(3), 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, smp(4), 1'b1, 1'b1);
        checks++;
        if (rd_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_valid got=%b want=0", rd_valid);
        end
    endtask

    task automatic test_reset_midread();
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
        for (int n = 1; n <= 8; n++) applyStimulus(1'b1, (n == 4), smp(n), 1'b0, 1'b0);
        drain(0, 2);
        Resetn = 1'b0;
        #1;
        checks++;
        if (state !== 2'd0 || rd_valid !== 1'b0 || rd_last !== 1'b0 || count !== 4'd0) begin
            failures++;
            $display("[TB] FAIL async_reset state=%0d valid=%b last=%b count=%0d want 0", state, rd_valid, rd_last, count);
        end
        mPhase = 0; preQ.delete(); postQ.delete();
        @(posedge CLK); #1;
        Resetn = 1'b1;
        test_basic();
    endtask

    task automatic test_random();
        int guard;
        for (int it = 0; it < 8; it++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
            for (int k = 0; k < int'($urandom_range(0, 12)); k++)
                applyStimulus(($urandom_range(0, 3) != 0), 1'b0, {$urandom, $urandom},
                              1'($urandom_range(0, 1)), 1'b0);
            applyStimulus(1'($urandom_range(0, 1)), 1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
            guard = 0;
            while (mPhase != 3 && guard < 100) begin
                applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);
                guard++;
            end
            drain(2, 100);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_trig_first();
        test_trig_novalid();
        test_wrap_stall();
        test_abort();
        test_basic();
        test_reset_midread();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
